// File: rtl/hazard_pkg.sv
// Shared constants and the tag-pipeline entry type for the hazard scoreboard.
// Entry fields are sized for the largest supported register/latency widths.
package hazard_pkg;

  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  localparam int RDY_ALU  = 2;
  localparam int RDY_LOAD = 3;

  localparam logic USE_D = 1'b0;
  localparam logic USE_E = 1'b1;

  localparam int TAG_RW   = 8;
  localparam int TAG_LATW = 4;

  typedef struct packed {
    logic                valid;
    logic [TAG_RW-1:0]   dst;
    logic [TAG_LATW-1:0] rdy;
  } tag_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Youngest-producer priority encoder: returns the forward select for one source
// and flags a producer whose result is not ready in time for the consumer.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int NST = 3,
  parameter int FW  = 2,
  parameter int LO  = 1
) (
  input  logic [TAG_RW-1:0] reg_i,
  input  logic              use_i,
  input  logic              slack_i,
  input  tag_t [NST:1]      ent_i,
  output logic [FW-1:0]     sel_o,
  output logic              late_o
);

  int hit_k;

  always_comb begin
    hit_k = 0;
    // Scan oldest to youngest so the smallest matching stage wins.
    for (int k = NST; k >= LO; k--) begin
      if (use_i && ent_i[k].valid && ent_i[k].dst == reg_i && reg_i != '0) hit_k = k;
    end
    sel_o  = '0;
    late_o = 1'b0;
    if (hit_k != 0) begin
      if (hit_k >= int'(ent_i[hit_k].rdy)) sel_o = FW'(hit_k);
      late_o = (hit_k + int'(slack_i)) < int'(ent_i[hit_k].rdy);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard scoreboard: shadow tag pipeline, stall/flush and forward selects,
// plus the MDU busy countdown. Define HAZARD_STALL_STAT_EN to add stall statistics counters.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NST     = 3,
  parameter int RW      = 5,
  parameter int LATW    = 3,
  parameter int MDU_LAT = 5,
  parameter int FW      = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RW-1:0]   RsD,
  input  logic [RW-1:0]   RtD,
  input  logic            UseRsD,
  input  logic            UseRtD,
  input  logic            UseStageD,
  input  logic            RegWriteD,
  input  logic [RW-1:0]   WriteRegD,
  input  logic [LATW-1:0] RdyStageD,
  input  logic            MDStartD,
  input  logic            MDUseD,
  input  logic            FlushAll,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushE,
  output logic            MulFlushE,
  output logic [FW-1:0]   ForwardAD,
  output logic [FW-1:0]   ForwardBD,
  output logic [FW-1:0]   ForwardAE,
  output logic [FW-1:0]   ForwardBE,
  output logic            BusyMD
`ifdef HAZARD_STALL_STAT_EN
  ,
  output logic [31:0]     StallCnt,
  output logic [31:0]     MduStallCnt
`endif
);

  localparam int MW = $clog2(MDU_LAT + 1);

  tag_t [NST:1]  ent_q, ent_d;
  logic          md_q, md_d;
  logic [RW-1:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d;
  logic          use_a_e_q, use_a_e_d, use_b_e_q, use_b_e_d;
  logic [MW-1:0] cnt_q, cnt_d;

  logic late_a, late_b, late_ae, late_be;
  logic data_stall, md_stall, stall, issue;
  logic unused_late;

  hazard_fwd_sel #(.NST(NST), .FW(FW), .LO(1)) u_sel_ad (
    .reg_i(TAG_RW'(RsD)), .use_i(UseRsD), .slack_i(UseStageD), .ent_i(ent_q),
    .sel_o(ForwardAD), .late_o(late_a));
  hazard_fwd_sel #(.NST(NST), .FW(FW), .LO(1)) u_sel_bd (
    .reg_i(TAG_RW'(RtD)), .use_i(UseRtD), .slack_i(UseStageD), .ent_i(ent_q),
    .sel_o(ForwardBD), .late_o(late_b));
  hazard_fwd_sel #(.NST(NST), .FW(FW), .LO(2)) u_sel_ae (
    .reg_i(TAG_RW'(rs_e_q)), .use_i(use_a_e_q), .slack_i(1'b0), .ent_i(ent_q),
    .sel_o(ForwardAE), .late_o(late_ae));
  hazard_fwd_sel #(.NST(NST), .FW(FW), .LO(2)) u_sel_be (
    .reg_i(TAG_RW'(rt_e_q)), .use_i(use_b_e_q), .slack_i(1'b0), .ent_i(ent_q),
    .sel_o(ForwardBE), .late_o(late_be));

  // E-side lateness cannot occur once D has stalled correctly.
  assign unused_late = late_ae | late_be;

  assign data_stall = late_a | late_b;
  assign md_stall   = MDUseD && (cnt_q != '0 || md_q);
  assign stall      = data_stall | md_stall;
  assign issue      = !stall && !FlushAll;

  assign StallF    = stall;
  assign StallD    = stall;
  assign FlushE    = stall;
  assign MulFlushE = md_stall && !data_stall;
  assign BusyMD    = cnt_q != '0;

  always_comb begin
    ent_d = ent_q;
    for (int k = NST; k >= 2; k--) ent_d[k] = ent_q[k-1];
    // Entries at stage 3 and beyond have committed and survive a squash.
    if (FlushAll) ent_d[2].valid = 1'b0;
    ent_d[1] = '0;
    if (issue) begin
      ent_d[1].valid = RegWriteD && WriteRegD != '0;
      ent_d[1].dst   = TAG_RW'(WriteRegD);
      ent_d[1].rdy   = TAG_LATW'(RdyStageD);
    end
    md_d      = issue && MDStartD;
    rs_e_d    = issue ? RsD : '0;
    rt_e_d    = issue ? RtD : '0;
    use_a_e_d = issue && UseRsD;
    use_b_e_d = issue && UseRtD;
    if (issue && MDStartD) cnt_d = MW'(MDU_LAT);
    else if (cnt_q != '0)  cnt_d = cnt_q - MW'(1);
    else                   cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q     <= '0;
      md_q      <= 1'b0;
      rs_e_q    <= '0;
      rt_e_q    <= '0;
      use_a_e_q <= 1'b0;
      use_b_e_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      ent_q     <= ent_d;
      md_q      <= md_d;
      rs_e_q    <= rs_e_d;
      rt_e_q    <= rt_e_d;
      use_a_e_q <= use_a_e_d;
      use_b_e_q <= use_b_e_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef HAZARD_STALL_STAT_EN
  logic [31:0] stall_cnt_q, mdu_stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q     <= '0;
      mdu_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q     <= stall_cnt_q + {31'b0, stall};
      mdu_stall_cnt_q <= mdu_stall_cnt_q + {31'b0, MulFlushE};
    end
  end

  assign StallCnt    = stall_cnt_q;
  assign MduStallCnt = mdu_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed and randomized bench for hazard_scoreboard against a rule-level model.
// Build with HAZARD_STALL_STAT_EN to also cover the statistics counters.
module tb_hazard_scoreboard;

  localparam int NST = 3, RW = 5, LATW = 3, MDU_LAT = 5, FW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [RW-1:0]   RsD, RtD, WriteRegD;
  logic            UseRsD, UseRtD, UseStageD, RegWriteD;
  logic [LATW-1:0] RdyStageD;
  logic            MDStartD, MDUseD, FlushAll;
  logic            StallF, StallD, FlushE, MulFlushE, BusyMD;
  logic [FW-1:0]   ForwardAD, ForwardBD, ForwardAE, ForwardBE;
`ifdef HAZARD_STALL_STAT_EN
  logic [31:0]     StallCnt, MduStallCnt;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.NST(NST), .RW(RW), .LATW(LATW), .MDU_LAT(MDU_LAT), .FW(FW)) dut (
    .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .UseRsD(UseRsD), .UseRtD(UseRtD),
    .UseStageD(UseStageD), .RegWriteD(RegWriteD), .WriteRegD(WriteRegD),
    .RdyStageD(RdyStageD), .MDStartD(MDStartD), .MDUseD(MDUseD), .FlushAll(FlushAll),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .MulFlushE(MulFlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .BusyMD(BusyMD)
`ifdef HAZARD_STALL_STAT_EN
    , .StallCnt(StallCnt), .MduStallCnt(MduStallCnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: in-flight producers by stage, E-stage sources, MDU countdown.
  int m_v[1:NST], m_dst[1:NST], m_rdy[1:NST];
  int m_md, m_cnt, m_rsE, m_rtE, m_uaE, m_ubE, m_sc, m_msc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 1; k <= NST; k++) begin
      m_v[k] = 0; m_dst[k] = 0; m_rdy[k] = 0;
    end
    m_md = 0; m_cnt = 0; m_rsE = 0; m_rtE = 0; m_uaE = 0; m_ubE = 0; m_sc = 0; m_msc = 0;
  endtask

  function automatic int ymatch(int r, int lo);
    for (int k = lo; k <= NST; k++)
      if (m_v[k] != 0 && m_dst[k] == r && r != 0) return k;
    return 0;
  endfunction

  function automatic int fwd(int r, int u, int lo);
    int k = ymatch(r, lo);
    if (u != 0 && k != 0 && k >= m_rdy[k]) return k;
    return 0;
  endfunction

  function automatic bit late(int r, int u, int slack);
    int k = ymatch(r, 1);
    return u != 0 && k != 0 && (k + slack) < m_rdy[k];
  endfunction

  task automatic nop();
    RsD = '0; RtD = '0; UseRsD = 0; UseRtD = 0; UseStageD = 1; RegWriteD = 0;
    WriteRegD = '0; RdyStageD = '0; MDStartD = 0; MDUseD = 0; FlushAll = 0;
  endtask

  // rs/rt with use bits, use stage, write flag, destination, ready stage
  task automatic op(input int rs, input int ua, input int rt, input int ub, input int us,
                    input int rw, input int wr, input int rdy);
    nop();
    RsD = RW'(rs); UseRsD = 1'(ua); RtD = RW'(rt); UseRtD = 1'(ub); UseStageD = 1'(us);
    RegWriteD = 1'(rw); WriteRegD = RW'(wr); RdyStageD = LATW'(rdy);
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic cyc();
    bit ds, ms, st, iss;
    #1;
    ds = late(int'(RsD), int'(UseRsD), int'(UseStageD)) ||
         late(int'(RtD), int'(UseRtD), int'(UseStageD));
    ms = MDUseD && (m_cnt != 0 || m_md != 0);
    st = ds || ms;
    chk("StallF", 32'(StallF), 32'(st));
    chk("StallD", 32'(StallD), 32'(st));
    chk("FlushE", 32'(FlushE), 32'(st));
    chk("MulFlushE", 32'(MulFlushE), 32'(ms && !ds));
    chk("ForwardAD", 32'(ForwardAD), 32'(fwd(int'(RsD), int'(UseRsD), 1)));
    chk("ForwardBD", 32'(ForwardBD), 32'(fwd(int'(RtD), int'(UseRtD), 1)));
    chk("ForwardAE", 32'(ForwardAE), 32'(fwd(m_rsE, m_uaE, 2)));
    chk("ForwardBE", 32'(ForwardBE), 32'(fwd(m_rtE, m_ubE, 2)));
    chk("BusyMD", 32'(BusyMD), 32'(m_cnt != 0));
`ifdef HAZARD_STALL_STAT_EN
    chk("StallCnt", StallCnt, 32'(m_sc));
    chk("MduStallCnt", MduStallCnt, 32'(m_msc));
    m_sc  += int'(st);
    m_msc += int'(ms && !ds);
`endif
    iss = !st && !FlushAll;
    for (int k = NST; k >= 2; k--) begin
      m_v[k] = m_v[k-1]; m_dst[k] = m_dst[k-1]; m_rdy[k] = m_rdy[k-1];
    end
    if (FlushAll) m_v[2] = 0;
    m_v[1]   = int'(iss && RegWriteD && WriteRegD != 0);
    m_dst[1] = int'(WriteRegD);
    m_rdy[1] = int'(RdyStageD);
    m_md     = int'(iss && MDStartD);
    m_rsE    = iss ? int'(RsD) : 0;
    m_rtE    = iss ? int'(RtD) : 0;
    m_uaE    = int'(iss && UseRsD);
    m_ubE    = int'(iss && UseRtD);
    if (iss && MDStartD) m_cnt = MDU_LAT;
    else if (m_cnt > 0)  m_cnt = m_cnt - 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    nop();
    repeat (n) cyc();
  endtask

  initial begin
    // Reset and first cycle after release
    nop();
    reset = 1'b1;
    m_reset();
    @(negedge clk);
    #1;
    chk("rst_StallD", 32'(StallD), 32'd0);
    chk("rst_BusyMD", 32'(BusyMD), 32'd0);
    chk("rst_ForwardAD", 32'(ForwardAD), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    op(8, 1, 9, 1, 0, 1, 10, 2); MDUseD = 1;
    #1;
    chk("post_rst_StallD", 32'(StallD), 32'd0);
    chk("post_rst_MulFlushE", 32'(MulFlushE), 32'd0);
    cyc();
    drain(4);

    // Load-use: lw $8 then addu reading $8 in E
    op(1, 1, 0, 0, 1, 1, 8, 3); cyc();
    op(8, 1, 2, 1, 1, 1, 10, 2);
    #1; chk("lu_stall", 32'(StallD), 32'd1);
    cyc();
    #1; chk("lu_issue", 32'(StallD), 32'd0);
    cyc();
    nop();
    #1; chk("lu_fwdAE", 32'(ForwardAE), 32'd3);
    cyc();
    drain(3);
    op(1, 1, 0, 0, 1, 1, 8, 3); cyc();
    op(2, 1, 3, 1, 1, 1, 11, 2); cyc();
    op(8, 1, 0, 0, 1, 1, 10, 2);
    #1; chk("lu_gap_nostall", 32'(StallD), 32'd0);
    cyc();
    drain(4);

    // ALU to branch, then load to branch
    op(1, 1, 2, 1, 1, 1, 9, 2); cyc();
    op(9, 1, 0, 0, 0, 0, 0, 0);
    #1; chk("alu_br_stall", 32'(StallD), 32'd1);
    cyc();
    #1; chk("alu_br_go", 32'(StallD), 32'd0);
    chk("alu_br_fwdAD", 32'(ForwardAD), 32'd2);
    cyc();
    drain(4);
    op(1, 1, 0, 0, 1, 1, 9, 3); cyc();
    op(9, 1, 0, 0, 0, 0, 0, 0);
    #1; chk("ld_br_stall1", 32'(StallD), 32'd1);
    cyc();
    #1; chk("ld_br_stall2", 32'(StallD), 32'd1);
    cyc();
    #1; chk("ld_br_go", 32'(StallD), 32'd0);
    chk("ld_br_fwdAD", 32'(ForwardAD), 32'd3);
    cyc();
    drain(4);

    // Writes to $0 never create hazards
    op(1, 1, 2, 1, 1, 1, 0, 2); cyc();
    op(0, 1, 0, 1, 0, 1, 13, 2);
    #1; chk("r0_stall", 32'(StallD), 32'd0);
    chk("r0_fwdAD", 32'(ForwardAD), 32'd0);
    chk("r0_fwdBD", 32'(ForwardBD), 32'd0);
    cyc();
    nop();
    #1; chk("r0_fwdAE", 32'(ForwardAE), 32'd0);
    cyc();
    drain(3);

    // MDU busy: mult then mflo
    nop(); MDStartD = 1; cyc();
    nop(); MDUseD = 1; RegWriteD = 1; WriteRegD = RW'(12); RdyStageD = LATW'(2);
    for (int i = 0; i < MDU_LAT; i++) begin
      #1;
      chk("md_stall", 32'(StallD), 32'd1);
      chk("md_mulflush", 32'(MulFlushE), 32'd1);
      chk("md_busy", 32'(BusyMD), 32'd1);
      cyc();
    end
    #1; chk("md_done_stall", 32'(StallD), 32'd0);
    chk("md_done_busy", 32'(BusyMD), 32'd0);
    cyc();
    drain(3);
    nop(); MDStartD = 1; cyc();
    op(1, 1, 2, 1, 1, 1, 14, 2);
    #1; chk("md_unrel_stall", 32'(StallD), 32'd0);
    cyc();
    drain(6);

    // FlushAll against a stalled consumer; the MDU keeps counting
    nop(); MDStartD = 1; cyc();
    op(1, 1, 0, 0, 1, 1, 8, 3); cyc();
    op(8, 1, 0, 0, 1, 1, 10, 2); FlushAll = 1;
    #1; chk("fl_stall", 32'(StallD), 32'd1);
    cyc();
    op(8, 1, 0, 0, 1, 1, 10, 2);
    #1; chk("fl_nostall", 32'(StallD), 32'd0);
    chk("fl_busy", 32'(BusyMD), 32'd1);
    chk("fl_fwdAD", 32'(ForwardAD), 32'd0);
    cyc();
    drain(6);

    // Reset in the middle of an MDU stall
    nop(); MDStartD = 1; cyc();
    nop(); MDUseD = 1; RegWriteD = 1; WriteRegD = RW'(12); RdyStageD = LATW'(2);
    cyc(); cyc();
    #1; chk("rs_pre_stall", 32'(StallD), 32'd1);
    reset = 1'b1;
    #1;
    chk("rs_StallD", 32'(StallD), 32'd0);
    chk("rs_StallF", 32'(StallF), 32'd0);
    chk("rs_FlushE", 32'(FlushE), 32'd0);
    chk("rs_MulFlushE", 32'(MulFlushE), 32'd0);
    chk("rs_BusyMD", 32'(BusyMD), 32'd0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    op(12, 1, 0, 0, 1, 1, 15, 2);
    #1; chk("rs_consumer", 32'(StallD), 32'd0);
    cyc();
    drain(6);

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      nop();
      RsD       = RW'($urandom_range(0, 3));
      RtD       = RW'($urandom_range(0, 3));
      UseRsD    = 1'($urandom_range(0, 1));
      UseRtD    = 1'($urandom_range(0, 1));
      UseStageD = 1'($urandom_range(0, 1));
      RegWriteD = 1'($urandom_range(0, 1));
      WriteRegD = RW'($urandom_range(0, 3));
      RdyStageD = LATW'($urandom_range(1, 3));
      MDStartD  = ($urandom_range(0, 7) == 0);
      MDUseD    = ($urandom_range(0, 5) == 0);
      FlushAll  = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the fixed 5-stage hazard unit.
- Holds its own shadow pipeline of destination tags for stages E..W, generalised to NST post-decode stages.
- Per-instruction result latency replaces the fixed ALU/load cases. Stall and forward selects are derived from this tag state.
- Owns the multiply/divide busy countdown. Sits beside the datapath and drives the F/D stall, E flush and all forward-mux selects.

Parameters:
- NST, 3, post-decode stages tracked (1=E, 2=M, ..., NST=W); legal range 2..6.
- RW, 5, register index width.
- LATW, 3, width of result-ready stage field.
- MDU_LAT, 5, cycles the MDU stays busy after start.
- FW, 2, forward select width; must be at least ceil(log2(NST+1)).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- RsD, RtD  in  RW  D-stage source registers.
- UseRsD, UseRtD  in  1  the source is actually read.
- UseStageD  in  1  0 = operand needed in D (branch/jr); 1 = needed in E.
- RegWriteD  in  1  D instruction writes a register.
- WriteRegD  in  RW  its destination register.
- RdyStageD  in  LATW  first stage whose output carries the result (ALU=2, load=3).
- MDStartD, MDUseD  in  1  D instruction starts / reads the MDU.
- FlushAll  in  1  exception squash of D and all younger-than-W entries.
- StallF, StallD, FlushE  out  1  pipeline control.
- MulFlushE  out  1  stall cause is MDU busy.
- ForwardAD, ForwardBD, ForwardAE, ForwardBE  out  FW  forward selects; 0 = register file, k = stage k.
- BusyMD  out  1  MDU counter non-zero.

Behaviour:
State:
- Tag pipeline entries 1..NST, each {valid, dst, rdy}.
- Source copies RsE/RtE with use bits.
- mdu_cnt.

Reset, asynchronous:
- All valid bits = 0, mdu_cnt = 0, RsE/RtE = 0.
- All outputs 0 while reset is high and in the first cycle after release.

Advance, every clock edge:
- Entry k+1 takes entry k, for k = 1..NST-1; entry NST is dropped.
- Entry 1 takes the D instruction if not StallD and not FlushAll, with valid = RegWriteD && WriteRegD != 0. Otherwise entry 1 becomes a bubble (valid = 0).
- FlushAll additionally clears entry 2. Entries at or above stage 3 have committed and are kept.

Match rule:
- match(r, k) = valid_k && dst_k == r && r != 0.
- Only the smallest matching k (youngest producer) is considered.

Stall:
- Raised for source r of D (with Use bit set) when youngest match k satisfies k + UseStageD < rdy_k.
- Also raised when MDUseD && (mdu_cnt != 0 || entry-1 MDU start pending).
- On stall: StallF = StallD = FlushE = 1, all in the same cycle, combinational.
- MulFlushE = 1 only when the MDU term is the sole cause.

Forwarding:
- ForwardAD/BD = youngest match k if k >= rdy_k, else 0.
- ForwardAE/BE use RsE/RtE against entries 2..NST with the same rule.
- A matching entry that is not yet ready yields select 0; the D-stage stall guarantees this never reaches use.

MDU counter:
- mdu_cnt loads MDU_LAT when MDStartD issues (no stall, no flush).
- Otherwise it decrements, saturating at 0.
- FlushAll does not clear mdu_cnt; the unit keeps running.

Simultaneous events:
- Stall and FlushAll together: the flush wins, D is not latched.
- The issuing instruction's own destination is never matched against itself.

Optional Feature:
- Macro: HAZARD_STALL_STAT_EN.
- With the macro defined:
  - Adds output StallCnt[31:0], counting cycles with StallD = 1.
  - Adds output MduStallCnt[31:0], counting cycles with MulFlushE = 1.
  - Both wrap at 2^32 and are cleared by reset only.
- Without the macro, neither the ports nor the counters exist.

Decomposition:
- Shared package hazard_pkg holds:
  - Stage index constants STG_E = 1, STG_M = 2, STG_W = 3.
  - RDY_ALU = 2, RDY_LOAD = 3.
  - USE_D / USE_E encodings.
  - The tag entry struct {valid, dst, rdy}.
- One natural sub-module, hazard_fwd_sel: a combinational youngest-ready-match priority encoder, instantiated four times (AD, BD, AE, BE).

Test Plan:
- Load-use: lw $8 (rdy 3), then addu reading $8 in E → one stall cycle, then ForwardAE = 3; no stall if one independent instruction sits between them.
- ALU to branch: addu $9, then beq $9 (UseStageD = 0) → one stall, then ForwardAD = 2; lw $9, then beq → two stalls, then ForwardAD = 3.
- $0 writes: RegWriteD with WriteRegD = 0, then a consumer of $0 → no stall, all forward selects 0.
- MDU: mult, then mflo on the next instruction → StallD and MulFlushE high for MDU_LAT cycles, BusyMD falls, then issue; mult followed by an unrelated addu → no stall.
- FlushAll while lw $8 is in E and a consumer is stalled in D → next cycle StallD = 0 and entries 1–2 invalid; mdu_cnt is unchanged.
- Reset asserted mid-stall (mdu_cnt = 3) → all outputs 0 immediately, state cleared; after release, a consumer issues without stall.
